instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Supplies 32-bit instruction words to the instruction decoder and owns the program counter.
- Fetches from instruction memory with a req/ack handshake and presents one instruction at a time, with its PC.
- Consumes the decoder's branch, branchLink, bOffset and conditionBool results to redirect the PC.
- Produces the link address that the register file writes to R14 on BL.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_ADDR, 32'h0000_0000, PC value after reset.
- FAULT_ADDR, 32'h0000_001C, redirect target on misaligned branch (optional feature only).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  ADDR_W  fetch address, equals pc while imem_req=1.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- stall  input  1  downstream cannot accept; hold the current instruction.
- branch  input  1  decoder flags a branch instruction.
- branchLink  input  1  decoder flags BL.
- conditionBool  input  1  decoder condition satisfied.
- bOffset  input  32  sign-extended, word-shifted branch offset.
- instruction  output  32  instruction word presented to the decoder.
- instr_valid  output  1  instruction/instr_pc are valid.
- instr_pc  output  ADDR_W  address of the presented instruction.
- link_addr  output  ADDR_W  return address for BL (instr_pc+4).
- link_we  output  1  one-cycle pulse: write link_addr to R14.
- fetch_fault  output  1  sticky misaligned-target flag (tied 0 without the optional feature).

Behaviour:
- Reset (sync, active-high; overrides everything, including an outstanding request):
  - pc=RESET_ADDR, state=FETCH.
  - imem_req=0, instruction=0, instr_valid=0, instr_pc=0, link_addr=0, link_we=0, fetch_fault=0.
  - imem_req is first asserted in the cycle after reset deasserts.
  - An imem_ack arriving during reset or in the cycle reset deasserts is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, imem_req<=0, go ISSUE.
  - Data is visible the cycle after ack (1-cycle latency). Zero-wait memory (ack in the first req cycle) is legal.
- ISSUE (instr_valid=1, imem_req=0). Branch inputs are sampled only in this state; they are ignored while instr_valid=0.
  - taken = branch & conditionBool.
  - Priority 1, taken: pc<=instr_pc+8+bOffset (mod 2^ADDR_W, wrap-around allowed), instr_valid<=0, go FETCH.
    - Taken overrides stall: the branch instruction is consumed even if stall=1.
    - If branchLink=1 also: link_addr<=instr_pc+4, link_we<=1 for exactly one cycle.
  - Priority 2, stall=1 and not taken: hold instruction, instr_pc, instr_valid and pc unchanged.
  - Priority 3, otherwise: instr_valid<=0, go FETCH (sequential pc already incremented).
- Throughput: at most one instruction per 2 cycles plus memory wait states; no prefetch, so no flush logic is needed.
- branchLink with branch=0 is ignored. Untaken BL (conditionBool=0) gives no link_we.
- PC is 32-bit unsigned; pc+4 wraps 0xFFFF_FFFC -> 0x0000_0000 without error.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: on a taken branch whose computed target has target[1:0]!=0:
  - pc<=FAULT_ADDR and fetch_fault<=1.
  - fetch_fault stays set until reset.
  - link_we behaves as normal.
- Undefined: target[1:0] is forced to 00 (word-aligned truncation) and fetch_fault is tied to 0.

Test Plan:
- Reset, then ack after 2 wait cycles with rdata=0xEA000004 -> imem_addr=0x0 while req; instruction=0xEA000004, instr_pc=0x0, instr_valid=1 one cycle after ack; next imem_addr=0x4.
- Instruction at 0x8 presented; branch=1, conditionBool=1, bOffset=0x10 -> next imem_addr=0x20; link_we stays 0.
- Same with branchLink=1 at instr_pc=0x100, bOffset=0xFFFF_FFF8 -> next fetch at 0x100, link_addr=0x104, link_we pulses 1 cycle.
- branch=1, conditionBool=0 at instr_pc=0x40 -> next fetch 0x44, no link_we.
- stall=1 for 3 cycles in ISSUE -> instruction/instr_pc stable, imem_req=0; releases to fetch pc+4. Then stall=1 with a taken branch -> redirect happens immediately.
- Assert reset mid-FETCH with ack arriving the same cycle -> data is discarded, outputs go to reset values, fetch restarts at RESET_ADDR. With FETCH_ALIGN_CHECK_EN, bOffset=0x2 taken -> pc=0x1C, fetch_fault=1 until reset.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the program counter, fetches one 32-bit word at a
// time over a req/ack handshake, presents it to the decoder with its PC and
// redirects the PC on taken branches (producing the BL link address).
// Optional build macro FETCH_ALIGN_CHECK_EN: a taken branch to a misaligned
// target redirects to FAULT_ADDR and sets the sticky fetch_fault flag.
// Without it, branch targets are truncated to a word boundary.
module instr_fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] FAULT_ADDR = ADDR_W'(32'h0000_001C)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch,
  input  logic              branchLink,
  input  logic              conditionBool,
  input  logic [31:0]       bOffset,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic              fetch_fault
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic                imem_req_reg;
  logic [31:0]         instr_reg;
  logic                instr_valid_reg;
  logic [ADDR_W-1:0]   instr_pc_reg;
  logic [ADDR_W-1:0]   link_addr_reg;
  logic                link_we_reg;

  logic                taken;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   redirect_pc;

  // Branch target is relative to the branch address plus 8 (pipeline view).
  assign taken  = branch & conditionBool;
  assign target = instr_pc_reg + ADDR_W'(8) + ADDR_W'(bOffset);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic fetch_fault_reg;

  assign misaligned  = (target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? FAULT_ADDR : target;

  // Sticky fault flag: set by a taken branch to a misaligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_fault_reg <= 1'b0;
    end else if (state_reg == ISSUE && taken && misaligned) begin
      fetch_fault_reg <= 1'b1;
    end
  end

  assign fetch_fault = fetch_fault_reg;
`else
  // Low target bits are dropped; FAULT_ADDR only matters with the check on.
  logic unused_align;

  assign redirect_pc  = {target[ADDR_W-1:2], 2'b00};
  assign unused_align = ^{FAULT_ADDR, target[1:0]};
  assign fetch_fault  = 1'b0;
`endif

  // Fetch/issue state machine with registered handshake and decoder outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_ADDR;
      imem_req_reg    <= 1'b0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      instr_pc_reg    <= '0;
      link_addr_reg   <= '0;
      link_we_reg     <= 1'b0;
    end else begin
      link_we_reg <= 1'b0;
      case (state_reg)
        FETCH: begin
          if (!imem_req_reg) begin
            // First cycle out of reset: raise the request, ignore any ack.
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= pc_reg;
            pc_reg          <= pc_reg + ADDR_W'(4);
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          if (taken) begin
            // A taken branch is consumed even while stalled.
            pc_reg          <= redirect_pc;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= FETCH;
            if (branchLink) begin
              link_addr_reg <= instr_pc_reg + ADDR_W'(4);
              link_we_reg   <= 1'b1;
            end
          end else if (!stall) begin
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instruction = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_pc    = instr_pc_reg;
  assign link_addr   = link_addr_reg;
  assign link_we     = link_we_reg;

endmodule
